// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request/response handshake bundle for instr_encoder
interface instr_encoder_if #(
   parameter int BIT_COUNT = 32
);
   logic                 InValid;
   logic                 InReady;
   logic                 Li;
   logic [2:0]           ImmSrc;
   logic [6:0]           Opcode;
   logic [2:0]           Funct3;
   logic [6:0]           Funct7;
   logic [4:0]           Rd;
   logic [4:0]           Rs1;
   logic [4:0]           Rs2;
   logic [BIT_COUNT-1:0] Imm;
   logic                 OutValid;
   logic                 OutReady;
   logic [31:0]          Instr;
   logic                 Last;
   logic                 ImmErr;

   modport master (
      output InValid, Li, ImmSrc, Opcode, Funct3, Funct7, Rd, Rs1, Rs2, Imm, OutReady,
      input  InReady, OutValid, Instr, Last, ImmErr
   );

   modport slave (
      input  InValid, Li, ImmSrc, Opcode, Funct3, Funct7, Rd, Rs1, Rs2, Imm, OutReady,
      output InReady, OutValid, Instr, Last, ImmErr
   );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - packs register/opcode/immediate into RV32 words, expands LI to LUI/ADDI
// Optional immediate range checking: define IMM_RANGE_CHECK_EN.
module instr_encoder #(
   parameter int BIT_COUNT = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   instr_encoder_if.slave       bus
);
   localparam logic [2:0] IMM_11T0 = 3'd0;
   localparam logic [2:0] IMM_4T0  = 3'd1;
   localparam logic [2:0] S_TYPE   = 3'd2;
   localparam logic [2:0] U_TYPE   = 3'd3;
   localparam logic [2:0] J_TYPE   = 3'd4;
   localparam logic [2:0] B_TYPE   = 3'd5;

   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_ADDI = 7'b0010011;

   typedef enum logic {IDLE, SECOND} state_t;

   state_t state, state_d;

   logic        out_valid;
   logic [31:0] instr;
   logic        last;
   logic        imm_err;
   logic [31:0] pend_instr;
   logic        pend_err;

   logic        in_ready;
   logic        accept;
   logic [31:0] enc_word;
   logic [31:0] enc_addi;
   logic        enc_two;
   logic        enc_err;
   logic [31:0] imm32;
   logic [31:0] hi_sum;
   logic [11:0] lo;

   // True when v is the sign extension of its low n bits.
   function automatic logic fits_signed(input logic [BIT_COUNT-1:0] v, input int n);
      logic [BIT_COUNT-1:0] s;
      s = $signed(v) >>> (n - 1);
      return (s == '0) || (&s);
   endfunction

   assign in_ready = (state == IDLE) && (!out_valid || bus.OutReady);
   assign accept   = bus.InValid && in_ready;

   always_comb begin
      enc_word = '0;
      enc_addi = '0;
      enc_two  = 1'b0;
      imm32    = bus.Imm[31:0];
      lo       = imm32[11:0];
      hi_sum   = imm32 + 32'h0000_0800;
      if (bus.Li) begin
         if (fits_signed(bus.Imm, 12)) begin
            enc_word = {lo, 5'd0, 3'b000, bus.Rd, OP_ADDI};
         end else if (lo == 12'd0) begin
            enc_word = {hi_sum[31:12], bus.Rd, OP_LUI};
         end else begin
            enc_word = {hi_sum[31:12], bus.Rd, OP_LUI};
            enc_addi = {lo, bus.Rd, 3'b000, bus.Rd, OP_ADDI};
            enc_two  = 1'b1;
         end
      end else begin
         case (bus.ImmSrc)
            IMM_11T0: enc_word = {imm32[11:0], bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
            IMM_4T0:  enc_word = {bus.Funct7, imm32[4:0], bus.Rs1, bus.Funct3, bus.Rd, bus.Opcode};
            S_TYPE:   enc_word = {imm32[11:5], bus.Rs2, bus.Rs1, bus.Funct3, imm32[4:0], bus.Opcode};
            U_TYPE:   enc_word = {imm32[31:12], bus.Rd, bus.Opcode};
            J_TYPE:   enc_word = {imm32[20], imm32[10:1], imm32[11], imm32[19:12], bus.Rd, bus.Opcode};
            B_TYPE:   enc_word = {imm32[12], imm32[10:5], bus.Rs2, bus.Rs1, bus.Funct3,
                                  imm32[4:1], imm32[11], bus.Opcode};
            default:  enc_word = {25'd0, bus.Opcode};
         endcase
      end
   end

`ifdef IMM_RANGE_CHECK_EN
   always_comb begin
      enc_err = 1'b0;
      if (bus.Li) begin
         enc_err = !fits_signed(bus.Imm, 32);
      end else begin
         case (bus.ImmSrc)
            IMM_11T0, S_TYPE: enc_err = !fits_signed(bus.Imm, 12);
            IMM_4T0:          enc_err = (bus.Imm >> 5) != '0;
            U_TYPE:           enc_err = (bus.Imm[11:0] != 12'd0) || !fits_signed(bus.Imm, 32);
            J_TYPE:           enc_err = bus.Imm[0] || !fits_signed(bus.Imm, 21);
            B_TYPE:           enc_err = bus.Imm[0] || !fits_signed(bus.Imm, 13);
            default:          enc_err = 1'b0;
         endcase
      end
   end
`else
   assign enc_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept && enc_two) state_d = SECOND;
         SECOND:  if (bus.OutReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The held ADDI replaces the LUI on its handshake; otherwise a new accept wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         instr      <= '0;
         last       <= 1'b0;
         imm_err    <= 1'b0;
         pend_instr <= '0;
         pend_err   <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         instr      <= enc_word;
         last       <= !enc_two;
         imm_err    <= enc_err;
         pend_instr <= enc_addi;
         pend_err   <= enc_err;
      end else if (state == SECOND && bus.OutReady) begin
         instr      <= pend_instr;
         last       <= 1'b1;
         imm_err    <= pend_err;
      end else if (bus.OutReady) begin
         out_valid  <= 1'b0;
      end
   end

   assign bus.InReady  = in_ready;
   assign bus.OutValid = out_valid;
   assign bus.Instr    = instr;
   assign bus.Last     = last;
   assign bus.ImmErr   = imm_err;
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the decode-stage immediate extender: packs a register/opcode/immediate request into a 32-bit RV32 instruction word, placing the immediate into the bit positions that the `immSrc` format selects. Also expands a load-immediate (LI) request into a one- or two-word LUI/ADDI sequence. It feeds the test-program generator and boot-stub writer through valid/ready handshakes on both sides. Output is registered.

## Interface
- `BIT_COUNT`, default 32: width of the `Imm` input (32 or 64).

- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `InValid` in 1: a request is present.
- `InReady` out 1: the block accepts the request on this edge.
- `Li` in 1: expand as load-immediate. `ImmSrc`, `Opcode`, `Funct3`, `Funct7`, `Rs1` and `Rs2` are ignored.
- `ImmSrc` in `immSrc` (HighLevelControl): Imm11t0, Imm4t0, SType, UType, JType or BType.
- `Opcode` in 7, `Funct3` in 3, `Funct7` in 7: copied into the instruction fields.
- `Rd`, `Rs1`, `Rs2` in 5 each: register indices.
- `Imm` in `BIT_COUNT`: immediate value, as a byte offset for J/B.
- `OutValid` out 1; `OutReady` in 1: output handshake.
- `Instr` out 32: encoded instruction word.
- `Last` out 1: this word is the final word of its request.
- `ImmErr` out 1: the immediate is not representable in the selected format.

## Operation
- Field placement. Every format puts `Opcode` at [6:0].
  - Imm11t0: [31:20]=Imm[11:0], [19:15]=Rs1, [14:12]=Funct3, [11:7]=Rd.
  - Imm4t0: [31:25]=Funct7, [24:20]=Imm[4:0], and the remaining fields as Imm11t0.
  - SType: [31:25]=Imm[11:5], [24:20]=Rs2, [19:15]=Rs1, [14:12]=Funct3, [11:7]=Imm[4:0].
  - UType: [31:12]=Imm[31:12], [11:7]=Rd.
  - JType: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12], [11:7]=Rd.
  - BType: [31]=Imm[12], [30:25]=Imm[10:5], [24:20]=Rs2, [19:15]=Rs1, [14:12]=Funct3, [11:8]=Imm[4:1], [7]=Imm[11].
- LI expansion:
  - lo = Imm[11:0].
  - hi = (Imm + 0x800)[31:12], computed at 32 bits with wrap.
  - If Imm fits 12-bit signed: emit ADDI Rd,x0,lo only.
  - Else if lo==0: emit LUI Rd,hi only.
  - Else: emit LUI Rd,hi, then ADDI Rd,Rd,lo.
  - Fixed encodings: LUI opcode 0110111; ADDI opcode 0010011 with Funct3 000.
- FSM states:
  - IDLE: no word pending.
  - SECOND: the LUI sits in the output register and the ADDI is held internally.
  - IDLE→SECOND when a two-word LI is accepted.
  - SECOND→IDLE when the LUI handshakes; the ADDI then loads into the output register with Last=1.
- Single-word requests set Last=1. The LUI of a two-word LI has Last=0.
- `InReady` = (state==IDLE) && (!OutValid || OutReady).

## Timing
- Latency: a request accepted at edge N gives `OutValid`=1 after edge N.
- Throughput: one single-word request per cycle. A two-word LI occupies two output cycles minimum, and `InReady`=0 while in SECOND.
- While `OutValid`=1 && `OutReady`=0, `Instr`, `Last` and `ImmErr` hold stable.
- Reset (`reset_n`=0 at an edge):
  - `OutValid`=0, `Instr`=0, `Last`=0, `ImmErr`=0, state=IDLE.
  - Reset mid-LI discards the pending ADDI.
  - Reset overrides a simultaneous accept.
- Simultaneous output handshake and new accept in IDLE: the new word replaces the old one with no bubble.

## Configuration
- `IMM_RANGE_CHECK_EN` defined:
  - Imm11t0/SType: Imm must be the sign-extension of Imm[11:0].
  - Imm4t0: Imm[BIT_COUNT-1:5] must be 0.
  - UType: Imm[11:0] must be 0 and Imm must fit 32-bit signed.
  - JType: Imm[0] must be 0 and Imm must fit 21-bit signed.
  - BType: Imm[0] must be 0 and Imm must fit 13-bit signed.
  - LI: Imm must fit 32-bit signed.
  - `ImmErr` is registered alongside the word. Both LI words carry it.
- Undefined: `ImmErr` is tied to 0. Out-of-range bits are silently truncated, and the encoding is otherwise identical.

## Test plan
- Imm11t0, Opcode=0010011, Funct3=000, Rd=5, Rs1=6, Imm=0xFFFFFFFF -> `Instr`=0xFFF30293, Last=1, ImmErr=0, one cycle after accept.
- BType, Opcode=1100011, Funct3=000, Rs1=1, Rs2=2, Imm=-4 -> `Instr`=0xFE208EE3. Same request with Imm=3 -> ImmErr=1 (macro on) or ImmErr=0 (macro off).
- Li, Rd=10, Imm=0x12345FFF -> 0x12346537 (Last=0), then 0xFFF50513 (Last=1). `InReady`=0 between the two words.
- Li, Rd=1, Imm=0x7FF -> single word 0x7FF00093. Li, Rd=1, Imm=0x00010000 -> single word 0x000100B7. Both have Last=1.
- Back-to-back Imm11t0 requests with `OutReady`=1 every cycle -> one word per cycle with no bubbles.
- During LI, hold `OutReady`=0 for 3 cycles -> `Instr` stays 0x12346537. Then assert `reset_n`=0 -> `OutValid`=0 next cycle and the ADDI is never emitted.
